instr_fetch: RTL and testbench

- Fetch initiator for the 16-bit-PC RISC-V core: owns the program counter, drives the instruction ROM address and captures the returned 32-bit word into a registered output stage.
- The output stage is handed to decode with a valid/ready handshake.
- Sits between the instruction ROM (asynchronous read, 2^14 x 32 bit) and the decode stage.
- Accepts branch/jump redirects from execute.

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_adder.sv | 26 ++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, reset constants and fetch state encoding
// Revision: 1.0
`default_nettype none

package instr_fetch_pkg;

  localparam int PC_W    = 16;
  localparam int ADDR_W  = 14;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC  = 16'h0000;
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h00000013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_adder.sv
// full_adder_16bit: 16-bit ripple-carry adder built from one-bit full-adder cells
// Revision: 1.0
`default_nettype none

module full_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [16:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = w_carry[16];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, ROM address generation and a valid/ready output stage to decode
// Revision: 1.0
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fault
);

  fetch_state_e       r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [PC_W-1:0]    r_ipc, w_ipc_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_fault, w_fault_nxt;
  logic [PC_W-1:0]    w_pc_inc;
  logic               w_pc_carry_unused;
  logic               w_load;

  // Carry-out is dropped so 16'hFFFC + 4 wraps to zero.
  full_adder_16bit u_pc_inc (
    .a     (r_pc),
    .b     (16'd4),
    .c_in  (1'b0),
    .sum   (w_pc_inc),
    .c_out (w_pc_carry_unused)
  );

  assign w_load = !r_valid || instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_instr <= INSTR_NOP;
      r_ipc   <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_ipc   <= w_ipc_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_ipc;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    case (r_state)
      RUN: begin
        // A redirect flushes the held instruction even when decode is ready.
        if (redirect_valid) begin
          w_valid_nxt = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            w_state_nxt = FAULT;
            w_fault_nxt = 1'b1;
          end else begin
            w_pc_nxt = redirect_pc;
          end
        end else if (w_load) begin
          w_instr_nxt = rom_data;
          w_ipc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_inc;
        end
      end
      FAULT: begin
        w_valid_nxt = 1'b0;
        w_fault_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = FAULT;
        w_valid_nxt = 1'b0;
        w_fault_nxt = 1'b1;
      end
    endcase
  end

  assign rom_addr    = r_pc[ADDR_W+1:2];
  assign instr_out   = r_instr;
  assign instr_pc    = r_ipc;
  assign instr_valid = r_valid;
  assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven, scoreboarded bench for instr_fetch with a synthetic ROM
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        fault;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  // ROM word n holds A000_0000 + n.
  assign rom_data = 32'hA000_0000 + {18'b0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] epc;
    logic [31:0] eout;
    logic [13:0] eaddr;
    logic        ef;
  } vec_t;

  vec_t tbl[20];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    instr_ready    = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    chk($sformatf("v%0d valid", n_vec), {31'b0, instr_valid}, {31'b0, e.ev});
    chk($sformatf("v%0d fault", n_vec), {31'b0, fault}, {31'b0, e.ef});
    chk($sformatf("v%0d rom_addr", n_vec), {18'b0, rom_addr}, {18'b0, e.eaddr});
    if (e.ev) begin
      chk($sformatf("v%0d instr_pc", n_vec), {16'b0, instr_pc}, {16'b0, e.epc});
      chk($sformatf("v%0d instr_out", n_vec), instr_out, e.eout);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, " fault"}, {31'b0, fault}, 32'd0);
    chk({tag, " rom_addr"}, {18'b0, rom_addr}, 32'd0);
    chk({tag, " instr_pc"}, {16'b0, instr_pc}, 32'd0);
    chk({tag, " instr_out"}, instr_out, 32'h0000_0013);
  endtask

  initial begin
    //         rdy   rv    rpc        ev    epc       eout            eaddr     ef
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hA000_0000, 14'h0001, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 32'hA000_0001, 14'h0002, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 32'hA000_0002, 14'h0003, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 32'hA000_0002, 14'h0003, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 32'hA000_0002, 14'h0003, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 32'hA000_0002, 14'h0003, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 32'hA000_0003, 14'h0004, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 32'hA000_0004, 14'h0005, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 32'h0000_0000, 14'h0040, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 32'hA000_0040, 14'h0041, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000, 32'h0000_0000, 14'h0080, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 32'hA000_0080, 14'h0081, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 32'hA000_0080, 14'h0081, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 16'hFFF8, 1'b0, 16'h0000, 32'h0000_0000, 14'h3FFE, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFF8, 32'hA000_3FFE, 14'h3FFF, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFC, 32'hA000_3FFF, 14'h0000, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hA000_0000, 14'h0001, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 16'h0102, 1'b0, 16'h0000, 32'h0000_0000, 14'h0001, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 32'h0000_0000, 14'h0001, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 32'h0000_0000, 14'h0001, 1'b1};

    rst            = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    #12;
    chk_reset_state("reset");
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_vec(tbl[i]);
    end

    // Reset clears the sticky fault and restarts at RESET_PC.
    rst = 1'b0;
    #1;
    chk_reset_state("fault_reset");
    #2;
    rst = 1'b1;
    run_vec('{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hA000_0000, 14'h0001, 1'b0});
    run_vec('{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 32'hA000_0001, 14'h0002, 1'b0});
    run_vec('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 32'hA000_0001, 14'h0002, 1'b0});

    // Asynchronous reset between edges while a stalled instruction is held.
    rst = 1'b0;
    #1;
    chk_reset_state("stall_reset");
    #2;
    rst = 1'b1;
    run_vec('{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 32'hA000_0000, 14'h0001, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
